pix_stream_tx: RTL

PIX_STREAM_TX -- requirements
Module: pix_stream_tx

---
 rtl/pix_stream_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pix_stream_tx.sv
// pix_stream_tx: reads a frame buffer in raster order and emits it as a ready/valid pixel stream.
// Optional macro PIX_STREAM_TX_SOF_EN adds m_user, a start-of-frame flag on the first pixel.
module pix_stream_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] width_m1,
  input  logic [10:0] height_m1,
  output logic [21:0] fb_raddr,
  output logic        fb_ren,
  input  logic [7:0]  fb_rdata,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_keep,
  input  logic        m_ready,
  output logic        busy,
  output logic        done
`ifdef PIX_STREAM_TX_SOF_EN
  ,
  output logic        m_user
`endif
);

`ifdef PIX_STREAM_TX_SOF_EN
  localparam int TW = 10;
`else
  localparam int TW = 9;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_r;
  logic [10:0]   w_r, h_r, col_r, row_r;
  logic [21:0]   addr_r;
  logic          fb_ren_r;
  logic [21:0]   fb_raddr_r;
  logic          ren_last_r;
  logic          pend_r, pend_last_r;
  logic [TW-1:0] mem_r [2];
  logic          rd_ptr_r, wr_ptr_r;
  logic [1:0]    count_r;
  logic          busy_r, done_r;
`ifdef PIX_STREAM_TX_SOF_EN
  logic          ren_first_r, pend_first_r;
`endif

  logic [TW-1:0] pend_word_s, head_s, out_word_s;
  logic [2:0]    entries_s;
  logic          valid_s, pop_s, push_s, fifo_pop_s, room_s, issue_s;
  logic          last_col_s, last_read_s, final_s;

`ifdef PIX_STREAM_TX_SOF_EN
  assign pend_word_s = {pend_first_r, pend_last_r, fb_rdata};
`else
  assign pend_word_s = {pend_last_r, fb_rdata};
`endif

  assign head_s      = mem_r[rd_ptr_r];
  assign valid_s     = (count_r != 2'd0) | pend_r;
  assign pop_s       = valid_s & m_ready;
  // Returning read data bypasses the FIFO only when it is empty and the datum is taken at once.
  assign push_s      = pend_r & ~((count_r == 2'd0) & pop_s);
  assign fifo_pop_s  = pop_s & (count_r != 2'd0);
  assign entries_s   = {1'b0, count_r} + {2'b00, pend_r} + {2'b00, fb_ren_r};
  assign room_s      = (entries_s - {2'b00, pop_s}) < 3'd2;
  assign issue_s     = (state_r == RUN) & room_s;
  assign last_col_s  = (col_r == w_r);
  assign last_read_s = last_col_s & (row_r == h_r);
  assign final_s     = (state_r == DRAIN) & pop_s & (entries_s == 3'd1);

  // Output word: FIFO head first, else the datum arriving from the frame buffer, else zero.
  always_comb begin
    out_word_s = {TW{1'b0}};
    if (count_r != 2'd0) begin
      out_word_s = head_s;
    end else if (pend_r) begin
      out_word_s = pend_word_s;
    end else begin
      out_word_s = {TW{1'b0}};
    end
  end

  assign m_data   = out_word_s[7:0];
  assign m_last   = out_word_s[8];
  assign m_valid  = valid_s;
  assign m_keep   = 1'b1;
  assign fb_ren   = fb_ren_r;
  assign fb_raddr = fb_raddr_r;
  assign busy     = busy_r;
  assign done     = done_r;
`ifdef PIX_STREAM_TX_SOF_EN
  assign m_user   = out_word_s[9];
`endif

  // Frame sequencer: accepts start, walks col/row and issues reads under FIFO credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      w_r        <= 11'd0;
      h_r        <= 11'd0;
      col_r      <= 11'd0;
      row_r      <= 11'd0;
      addr_r     <= 22'd0;
      fb_ren_r   <= 1'b0;
      fb_raddr_r <= 22'd0;
      ren_last_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef PIX_STREAM_TX_SOF_EN
      ren_first_r <= 1'b0;
`endif
    end else begin
      fb_ren_r <= 1'b0;
      done_r   <= final_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            w_r        <= width_m1;
            h_r        <= height_m1;
            fb_ren_r   <= 1'b1;
            fb_raddr_r <= 22'd0;
            ren_last_r <= (width_m1 == 11'd0);
            addr_r     <= 22'd1;
            busy_r     <= 1'b1;
`ifdef PIX_STREAM_TX_SOF_EN
            ren_first_r <= 1'b1;
`endif
            if (width_m1 == 11'd0) begin
              col_r <= 11'd0;
              row_r <= 11'd1;
            end else begin
              col_r <= 11'd1;
              row_r <= 11'd0;
            end
            if ((width_m1 == 11'd0) && (height_m1 == 11'd0)) begin
              state_r <= DRAIN;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          if (issue_s) begin
            fb_ren_r   <= 1'b1;
            fb_raddr_r <= addr_r;
            ren_last_r <= last_col_s;
            addr_r     <= addr_r + 22'd1;
`ifdef PIX_STREAM_TX_SOF_EN
            ren_first_r <= 1'b0;
`endif
            if (last_col_s) begin
              col_r <= 11'd0;
              row_r <= row_r + 11'd1;
            end else begin
              col_r <= col_r + 11'd1;
            end
            if (last_read_s) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (final_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read-return tracking and the 2-entry output FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r      <= 1'b0;
      pend_last_r <= 1'b0;
      mem_r[0]    <= {TW{1'b0}};
      mem_r[1]    <= {TW{1'b0}};
      rd_ptr_r    <= 1'b0;
      wr_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
`ifdef PIX_STREAM_TX_SOF_EN
      pend_first_r <= 1'b0;
`endif
    end else begin
      pend_r      <= fb_ren_r;
      pend_last_r <= ren_last_r;
`ifdef PIX_STREAM_TX_SOF_EN
      pend_first_r <= ren_first_r;
`endif
      if (push_s) begin
        mem_r[wr_ptr_r] <= pend_word_s;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (fifo_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push_s} - {1'b0, fifo_pop_s};
    end
  end

endmodule
